// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done handshake, operand bus, MTHI/MTLO write port and HI/LO read-out for muldiv_ctrl
//   master: drives start, op, a, b, hi_we, lo_we, wdata; observes busy, done, hi, lo
//   slave : the sequencer side (muldiv_ctrl)
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, a, b, hi_we, lo_we, wdata, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_if : muldiv_if.slave -- start/op/a/b request, hi_we/lo_we/wdata MTHI/MTLO port,
//            busy (pipeline stall), done (one-cycle pulse), hi/lo register outputs
//   op     : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   Build option MULDIV_DIV_EN: when defined the restoring divider is compiled in; when
//   undefined, starts with op[1]=1 are ignored and only multiplies run.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus_if
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;

    logic               accept;
    logic               b_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] prod;

    // Signed ops use two's-complement magnitudes; the most-negative value maps to itself,
    // which is still the correct unsigned magnitude.
    assign a_mag  = (bus_if.op[0] && bus_if.a[WIDTH-1]) ? -bus_if.a : bus_if.a;
    assign b_mag  = (bus_if.op[0] && bus_if.b[WIDTH-1]) ? -bus_if.b : bus_if.b;
    assign b_zero = bus_if.b == '0;

    // Shift-add: multiplier sits in the low half of acc and is consumed LSB first.
    assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {msum, acc_q[WIDTH-1:1]};
    assign prod     = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    logic             div_q, div_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] diff;
    logic             qbit;

    assign accept = bus_if.start;
    // Restoring step: the dividend shifts out of acc's low half MSB first while quotient
    // bits shift in behind it. A successful subtract always leaves less than the divisor,
    // so WIDTH bits hold the difference.
    assign shl  = {rem_q, acc_q[WIDTH-1]};
    assign qbit = shl >= {1'b0, opnd_q};
    assign diff = WIDTH'(shl - {1'b0, opnd_q});
`else
    assign accept = bus_if.start && !bus_if.op[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            div_q   <= div_d;
            rneg_q  <= rneg_d;
            rem_q   <= rem_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
        div_d   = div_q;
        rneg_d  = rneg_q;
        rem_d   = rem_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!bus_if.start) begin
                    if (bus_if.hi_we) hi_d = bus_if.wdata;
                    if (bus_if.lo_we) lo_d = bus_if.wdata;
                end
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    // Divide by zero keeps the all-ones quotient unsigned.
                    neg_d   = bus_if.op[0] && (bus_if.a[WIDTH-1] ^ bus_if.b[WIDTH-1])
                              && !(bus_if.op[1] && b_zero);
                    opnd_d  = bus_if.op[1] ? b_mag : a_mag;
                    acc_d   = {{WIDTH{1'b0}}, bus_if.op[1] ? a_mag : b_mag};
`ifdef MULDIV_DIV_EN
                    div_d   = bus_if.op[1];
                    // Remainder follows the dividend sign; with b=0 this restores the original a.
                    rneg_d  = bus_if.op == 2'b11 && bus_if.a[WIDTH-1];
                    rem_d   = '0;
`endif
                end
            end
            RUN: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == LAST ? FIX : RUN;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    rem_d              = qbit ? diff : shl[WIDTH-1:0];
                    acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], qbit};
                end else begin
                    acc_d = mul_step;
                end
`else
                acc_d = mul_step;
`endif
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                hi_d = div_q ? (rneg_q ? -rem_q : rem_q) : prod[2*WIDTH-1:WIDTH];
                lo_d = div_q ? (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]) : prod[WIDTH-1:0];
`else
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_if.busy = state_q != IDLE;
    assign bus_if.done = done_q;
    assign bus_if.hi   = hi_q;
    assign bus_if.lo   = lo_q;
endmodule
